fa_bl: RTL and testbench
========================

// Module: fa_bl
// PURPOSE
//  - Registered full adder: sum/carry of ip1 + ip2 + ip3 (ip3 = carry-in), one-cycle latency.
//  - Generic ripple-carry chain, parameterised width; WIDTH=1 is the classic 1-bit full adder.
//  - Leaf arithmetic block for datapaths that need a clocked, resettable add.
// PARAMETERS
//  - WIDTH  1  operand width in bits (>=1); ip1, ip2 and sum are WIDTH bits wide
// PORTS
//  - clk        in   1      sole clock; all state updates on rising edge
//  - rst        in   1      synchronous, active-high reset
//  - ip1        in   WIDTH  addend A
//  - ip2        in   WIDTH  addend B
//  - ip3        in   1      carry-in
//  - in_valid   in   1      ip1/ip2/ip3 are valid this cycle
//  - carry      out  1      registered carry-out of the MSB stage
//  - sum        out  WIDTH  registered sum, bits [WIDTH-1:0] of ip1+ip2+ip3
//  - out_valid  out  1      carry/sum hold a fresh result
// BEHAVIOUR
//  - Per bit i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = ip3.
//  - {carry,sum} = ip1 + ip2 + ip3, exact (WIDTH+1)-bit result; no overflow or saturation.
//  - Reset (rst=1 at a clk edge): carry=0, sum=0, out_valid=0; overrides in_valid in the same cycle.
//  - in_valid=1 at edge N: carry/sum take the result at edge N; out_valid=1 after edge N.
//  - in_valid=0 at edge N: carry/sum hold their value; out_valid=0 after edge N.
//  - Back-to-back valids: one result per cycle, no bubbles, no backpressure.
//  - Inputs may change every cycle; only values present at the sampling edge matter.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  - Macro FA_BL_STATS_EN:
//    - defined: adds outputs add_cnt[15:0] and carry_cnt[15:0].
//      - add_cnt increments on every accepted in_valid.
//      - carry_cnt increments when an accepted add produces carry=1.
//      - both wrap 0xFFFF->0; both clear to 0 on rst.
//    - undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Shared package fa_pkg: constant FA_STATS_W=16; function fa_bit_f(a,b,c) returning {cout,s}.
//  - Sub-module fa_bit: combinational 1-bit cell (a,b,cin -> s,cout).
//    - WIDTH copies instantiated in a generate chain.
//    - Output register stage and counters live in fa_bl.
// TESTING
//  - Exhaustive 1-bit truth table, WIDTH=1, in_valid=1, 8 input combos:
//    - 000->c0s0, 001->c0s1, 010->c0s1, 011->c1s0;
//    - 100->c0s1, 101->c1s0, 110->c1s0, 111->c1s1; each one cycle later.
//  - Reset: drive 111 with in_valid=1 and rst=1 -> carry=0, sum=0, out_valid=0 after the edge.
//  - Hold: result 111 then in_valid=0 with inputs 000 -> carry=1, sum=1 held, out_valid=0.
//  - WIDTH=8 boundary, in_valid=1:
//    - 0xFF+0x00+1 -> carry=1, sum=0x00;
//    - 0xFF+0xFF+1 -> carry=1, sum=0xFF;
//    - 0x00+0x00+0 -> carry=0, sum=0x00.
//  - Throughput: 8 consecutive valid cycles -> 8 consecutive out_valid=1 with matching results.
//  - FA_BL_STATS_EN: 8 truth-table adds -> add_cnt=8, carry_cnt=4.
//    - 65536 adds -> add_cnt wraps to 0.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared definitions for the registered full adder (fa_bl) and its 1-bit cell.
package fa_pkg;

   // Width of the optional add / carry statistics counters.
   localparam int FA_STATS_W = 16;

   // One full-adder bit: returns {cout, s} for inputs a, b and carry-in c.
   function automatic logic [1:0] fa_bit_f(input logic a, input logic b, input logic c);
      logic p;
      p = a ^ b;
      return {(a & b) | (c & p), p ^ c};
   endfunction

endpackage : fa_pkg

// File: rtl/fa_bit.sv
// Combinational 1-bit full-adder cell; one copy per bit of the fa_bl ripple chain.
module fa_bit
   import fa_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign {cout, s} = fa_bit_f(a, b, cin);

endmodule : fa_bit

// File: rtl/fa_bl.sv
// Registered ripple-carry full adder: {carry, sum} = ip1 + ip2 + ip3, one-cycle latency.
// Optional statistics counters (add_cnt, carry_cnt) are built when FA_BL_STATS_EN is defined.
module fa_bl
   import fa_pkg::*;
#(
   parameter int WIDTH = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      ip1,
   input  logic [WIDTH-1:0]      ip2,
   input  logic                  ip3,
   input  logic                  in_valid,
   output logic                  carry,
   output logic [WIDTH-1:0]      sum,
   output logic                  out_valid
`ifdef FA_BL_STATS_EN
   ,
   output logic [FA_STATS_W-1:0] add_cnt,
   output logic [FA_STATS_W-1:0] carry_cnt
`endif
);

   // Ripple chain: c[0] is the external carry-in, c[WIDTH] the final carry-out.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = ip3;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      fa_bit u_bit (
         .a    (ip1[i]),
         .b    (ip2[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   // Output register: capture the result on a valid input, otherwise hold; valid flag follows in_valid.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
      if (rst) begin
         carry     <= 1'b0;
         sum       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            carry <= c[WIDTH];
            sum   <= s;
         end
      end
   end

`ifdef FA_BL_STATS_EN
   localparam logic [FA_STATS_W-1:0] CNT_ONE = FA_STATS_W'(1);

   // Statistics: count accepted adds and those producing a carry-out; both wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         add_cnt   <= '0;
         carry_cnt <= '0;
      end else if (in_valid) begin
         add_cnt <= add_cnt + CNT_ONE;
         if (c[WIDTH]) begin
            carry_cnt <= carry_cnt + CNT_ONE;
         end
      end
   end
`endif

endmodule : fa_bl

// File: tb/tb_fa_bl.sv
// Self-checking bench for fa_bl: WIDTH=1 truth table, reset/hold, WIDTH=8 boundaries,
// throughput and random traffic against an arithmetic reference; statistics under FA_BL_STATS_EN.
module tb_fa_bl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // WIDTH=1 instance
   logic       a1, b1, c1, v1;
   logic       carry1, sum1, ov1;
   // WIDTH=8 instance
   logic [7:0] a8, b8;
   logic       c8, v8;
   logic       carry8, ov8;
   logic [7:0] sum8;

`ifdef FA_BL_STATS_EN
   logic [15:0] add_cnt1, carry_cnt1, add_cnt8, carry_cnt8;
`endif

   fa_bl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .ip1       (a1),
      .ip2       (b1),
      .ip3       (c1),
      .in_valid  (v1),
      .carry     (carry1),
      .sum       (sum1),
      .out_valid (ov1)
`ifdef FA_BL_STATS_EN
      ,
      .add_cnt   (add_cnt1),
      .carry_cnt (carry_cnt1)
`endif
   );

   fa_bl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .ip1       (a8),
      .ip2       (b8),
      .ip3       (c8),
      .in_valid  (v8),
      .carry     (carry8),
      .sum       (sum8),
      .out_valid (ov8)
`ifdef FA_BL_STATS_EN
      ,
      .add_cnt   (add_cnt8),
      .carry_cnt (carry_cnt8)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic a, b, c;
      logic ec, es;
   } tt_vec_t;

   typedef struct {
      logic [7:0] a, b;
      logic       c;
      logic       ec;
      logic [7:0] es;
   } w8_vec_t;

   tt_vec_t tt[8];
   w8_vec_t bnd[3];

   // Reference model for the 8-bit instance: plain integer addition, hold when not valid.
   logic       m_carry;
   logic [7:0] m_sum;
   logic       m_valid;

   task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
      int t;
      if (v) begin
         t       = int'(a) + int'(b) + int'(c);
         m_sum   = t[7:0];
         m_carry = t[8];
      end
      m_valid = v;
   endtask

   initial begin
      tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      bnd[0] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
      bnd[1] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF};
      bnd[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00};

      // Initial reset of both instances.
      rst = 1'b1;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
      a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; v8 = 1'b0;
      tick();
      tick();
      check("reset_carry1", 32'(carry1), 32'd0);
      check("reset_sum1",   32'(sum1),   32'd0);
      check("reset_ov1",    32'(ov1),    32'd0);
      rst = 1'b0;

      // Exhaustive 1-bit truth table, one cycle latency each.
      for (int i = 0; i < 8; i++) begin
         a1 = tt[i].a; b1 = tt[i].b; c1 = tt[i].c; v1 = 1'b1;
         tick();
         check($sformatf("tt%0d_carry", i), 32'(carry1), 32'(tt[i].ec));
         check($sformatf("tt%0d_sum", i),   32'(sum1),   32'(tt[i].es));
         check($sformatf("tt%0d_valid", i), 32'(ov1),    32'd1);
      end
`ifdef FA_BL_STATS_EN
      check("stats_add_cnt_8",   32'(add_cnt1),   32'd8);
      check("stats_carry_cnt_4", 32'(carry_cnt1), 32'd4);
`endif

      // Reset overrides a simultaneous valid input.
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
      rst = 1'b1;
      tick();
      check("rst_ovr_carry1", 32'(carry1), 32'd0);
      check("rst_ovr_sum1",   32'(sum1),   32'd0);
      check("rst_ovr_ov1",    32'(ov1),    32'd0);
      check("rst_ovr_carry8", 32'(carry8), 32'd0);
      check("rst_ovr_sum8",   32'(sum8),   32'd0);
      check("rst_ovr_ov8",    32'(ov8),    32'd0);
      rst = 1'b0;
      v8 = 1'b0;

      // Hold: result of 111, then idle inputs 000 must not disturb it.
      tick();
      check("hold_load_carry", 32'(carry1), 32'd1);
      check("hold_load_sum",   32'(sum1),   32'd1);
      check("hold_load_valid", 32'(ov1),    32'd1);
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("hold%0d_carry", k), 32'(carry1), 32'd1);
         check($sformatf("hold%0d_sum", k),   32'(sum1),   32'd1);
         check($sformatf("hold%0d_valid", k), 32'(ov1),    32'd0);
      end

      // WIDTH=8 boundaries.
      m_carry = 1'b0; m_sum = 8'h00; m_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a8 = bnd[i].a; b8 = bnd[i].b; c8 = bnd[i].c; v8 = 1'b1;
         tick();
         check($sformatf("bnd%0d_carry", i), 32'(carry8), 32'(bnd[i].ec));
         check($sformatf("bnd%0d_sum", i),   32'(sum8),   32'(bnd[i].es));
         check($sformatf("bnd%0d_valid", i), 32'(ov8),    32'd1);
      end

      // Throughput: 8 back-to-back valid cycles, a fresh result every cycle.
      for (int i = 0; i < 8; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); v8 = 1'b1;
         model8(a8, b8, c8, v8);
         tick();
         check($sformatf("thru%0d_valid", i), 32'(ov8),           32'd1);
         check($sformatf("thru%0d_result", i), {23'd0, carry8, sum8}, {23'd0, m_carry, m_sum});
      end

      // Random traffic with random gaps against the reference model.
      for (int i = 0; i < 200; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
         v8 = ($urandom_range(0, 3) != 0);
         model8(a8, b8, c8, v8);
         tick();
         check($sformatf("rnd%0d_valid", i),  32'(ov8),               32'(m_valid));
         check($sformatf("rnd%0d_result", i), {23'd0, carry8, sum8}, {23'd0, m_carry, m_sum});
      end
      v8 = 1'b0;

`ifdef FA_BL_STATS_EN
      // Counter wrap: 65536 accepted adds of 0+0+0 bring add_cnt back to zero.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
      for (int n = 0; n < 65535; n++) begin
         tick();
      end
      check("stats_add_cnt_max",  32'(add_cnt1),   32'h0000FFFF);
      tick();
      check("stats_add_cnt_wrap", 32'(add_cnt1),   32'd0);
      check("stats_carry_cnt_0",  32'(carry_cnt1), 32'd0);
      v1 = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fa_bl
